// File: rtl/ofmap_collector_if.sv
// Handshake bundle of the ofmap collector: TPU capture side (in_*) and drain stream (out_*).
interface ofmap_collector_if #(
    parameter int outputSize    = 24,
    parameter int numOutChannel = 3,
    parameter int numPixels     = 256,
    parameter int outDataSize   = 8
);
    localparam int pixAddrSize = $clog2(numPixels);
    localparam int chSize      = (numOutChannel > 32'sd1) ? $clog2(numOutChannel) : 32'sd1;

    logic [outputSize-1:0]  in_data [numOutChannel];
    logic                   in_valid;
    logic                   in_done;
    logic [outDataSize-1:0] out_data;
    logic [pixAddrSize-1:0] out_pix;
    logic [chSize-1:0]      out_ch;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output in_data, in_valid, in_done, out_ready,
        input  out_data, out_pix, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_done, out_ready,
        output out_data, out_pix, out_ch, out_valid
    );
endinterface

// File: rtl/ofmap_collector.sv
// Captures deskewed accumulator pixels, requantizes them to outDataSize signed values,
// buffers a whole job and then drains it pixel-major/channel-minor over valid/ready.
module ofmap_collector #(
    parameter int outputSize    = 24,
    parameter int numOutChannel = 3,
    parameter int numPixels     = 256,
    parameter int outDataSize   = 8
) (
    input  logic                    clk,
    input  logic                    nrst,
    ofmap_collector_if.slave        bus,
    input  logic                    ctrl_start,
    input  logic [15:0]             cfg_num_pixels,
    input  logic [4:0]              cfg_shift,
    output logic                    flag_busy,
    output logic                    flag_done,
    output logic                    flag_overflow
);
    localparam int pixAddrSize = $clog2(numPixels);
    localparam int chSize      = (numOutChannel > 32'sd1) ? $clog2(numOutChannel) : 32'sd1;
    localparam int wordW       = numOutChannel * outDataSize;

    localparam logic [15:0]        MAX_PIX = 16'(numPixels);
    localparam logic [chSize-1:0]  LAST_CH = chSize'(numOutChannel - 32'sd1);
    localparam logic signed [outputSize-1:0] SAT_MAX =
        {{(outputSize-outDataSize+1){1'b0}}, {(outDataSize-1){1'b1}}};
    localparam logic signed [outputSize-1:0] SAT_MIN =
        {{(outputSize-outDataSize+1){1'b1}}, {(outDataSize-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [15:0]            num_pix_r;
    logic [4:0]             shift_r;
    logic [15:0]            pix_cnt_r;
    logic [15:0]            pix_cnt_inc_s;
    logic [15:0]            cap_cnt_s;
    logic [15:0]            drain_len_r;
    logic [15:0]            drain_len_s;
    logic [15:0]            rd_pix_r;
    logic [chSize-1:0]      rd_ch_r;
    logic                   overflow_r;
    logic                   busy_r;
    logic                   done_r;
    logic [outDataSize-1:0] out_data_r;
    logic [pixAddrSize-1:0] out_pix_r;
    logic [chSize-1:0]      out_ch_r;
    logic                   out_valid_r;
    logic [wordW-1:0]       buf_r [numPixels];
    logic [wordW-1:0]       wr_word_s;
    logic [wordW-1:0]       rd_word_s;
    logic                   have_elem_s;
    logic                   start_s;
    logic                   cap_wr_s;
    logic                   cap_end_s;
    logic                   drain_load_s;
    logic                   drain_fetch_s;
    logic                   drain_fin_s;

    // Floor-rounded arithmetic shift followed by saturation to the output range.
    function automatic logic [outDataSize-1:0] requant(
        input logic [outputSize-1:0] word,
        input logic [4:0]            sh
    );
        logic signed [outputSize-1:0] shifted_s;
        if ({27'd0, sh} >= 32'(outputSize)) begin
            shifted_s = word[outputSize-1] ? '1 : '0;
        end else begin
            shifted_s = $signed(word) >>> sh;
        end
        if (shifted_s > SAT_MAX) begin
            return SAT_MAX[outDataSize-1:0];
        end else if (shifted_s < SAT_MIN) begin
            return SAT_MIN[outDataSize-1:0];
        end else begin
            return shifted_s[outDataSize-1:0];
        end
    endfunction

    assign pix_cnt_inc_s = pix_cnt_r + 16'd1;
    assign have_elem_s   = (rd_pix_r < drain_len_r);
    assign rd_word_s     = buf_r[rd_pix_r[pixAddrSize-1:0]];

    // Requantize every channel of the incoming pixel into one packed buffer word.
    always_comb begin
        wr_word_s = '0;
        for (int c = 0; c < numOutChannel; c++) begin
            wr_word_s[c*outDataSize +: outDataSize] = requant(bus.in_data[c], shift_r);
        end
    end

    // Drain length is the captured count including a pixel written on the final cycle, clamped to the buffer.
    always_comb begin
        cap_cnt_s   = pix_cnt_r;
        drain_len_s = MAX_PIX;
        if (cap_wr_s) begin
            cap_cnt_s = pix_cnt_inc_s;
        end else begin
            cap_cnt_s = pix_cnt_r;
        end
        if (cap_cnt_s > MAX_PIX) begin
            drain_len_s = MAX_PIX;
        end else begin
            drain_len_s = cap_cnt_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        state_nxt_s   = state_r;
        start_s       = 1'b0;
        cap_wr_s      = 1'b0;
        cap_end_s     = 1'b0;
        drain_load_s  = 1'b0;
        drain_fetch_s = 1'b0;
        drain_fin_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (ctrl_start) begin
                    start_s     = 1'b1;
                    state_nxt_s = (cfg_num_pixels == 16'd0) ? DRAIN : CAPTURE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CAPTURE: begin
                cap_wr_s = bus.in_valid;
                if ((bus.in_valid && (pix_cnt_inc_s == num_pix_r)) || bus.in_done) begin
                    cap_end_s   = 1'b1;
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = CAPTURE;
                end
            end
            DRAIN: begin
                // The output slot can be refilled when empty or when its element is taken this cycle.
                drain_load_s = !out_valid_r || bus.out_ready;
                if (drain_load_s && have_elem_s) begin
                    drain_fetch_s = 1'b1;
                    state_nxt_s   = DRAIN;
                end else if (drain_load_s) begin
                    drain_fin_s   = 1'b1;
                    state_nxt_s   = IDLE;
                end else begin
                    state_nxt_s   = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Job configuration, capture counter, drain length and sticky overflow.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            num_pix_r   <= 16'd0;
            shift_r     <= 5'd0;
            pix_cnt_r   <= 16'd0;
            drain_len_r <= 16'd0;
            overflow_r  <= 1'b0;
        end else begin
            if (start_s) begin
                num_pix_r   <= cfg_num_pixels;
                shift_r     <= cfg_shift;
                pix_cnt_r   <= 16'd0;
                drain_len_r <= 16'd0;
                overflow_r  <= 1'b0;
            end else if (cap_wr_s) begin
                pix_cnt_r <= pix_cnt_inc_s;
                if (pix_cnt_r >= MAX_PIX) begin
                    overflow_r <= 1'b1;
                end
            end
            if (cap_end_s) begin
                drain_len_r <= drain_len_s;
            end
        end
    end

    // Ofmap storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (cap_wr_s && (pix_cnt_r < MAX_PIX)) begin
            buf_r[pix_cnt_r[pixAddrSize-1:0]] <= wr_word_s;
        end
    end

    // Drain read pointer, registered output slot and status flags.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rd_pix_r    <= 16'd0;
            rd_ch_r     <= '0;
            out_data_r  <= '0;
            out_pix_r   <= '0;
            out_ch_r    <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != IDLE);
            done_r <= drain_fin_s;
            if (start_s) begin
                rd_pix_r <= 16'd0;
                rd_ch_r  <= '0;
            end else if (drain_fetch_s) begin
                out_data_r  <= rd_word_s[int'(rd_ch_r)*outDataSize +: outDataSize];
                out_pix_r   <= rd_pix_r[pixAddrSize-1:0];
                out_ch_r    <= rd_ch_r;
                out_valid_r <= 1'b1;
                if (rd_ch_r == LAST_CH) begin
                    rd_ch_r  <= '0;
                    rd_pix_r <= rd_pix_r + 16'd1;
                end else begin
                    rd_ch_r  <= rd_ch_r + chSize'(1'b1);
                end
            end else if (drain_fin_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.out_data   = out_data_r;
    assign bus.out_pix    = out_pix_r;
    assign bus.out_ch     = out_ch_r;
    assign bus.out_valid  = out_valid_r;
    assign flag_busy      = busy_r;
    assign flag_done      = done_r;
    assign flag_overflow  = overflow_r;
endmodule

// File: doc/ofmap_collector.md
Name: ofmap_collector

Overview:
- Output-side counterpart to the activation write path of the systolic TPU system.
- Captures the deskewed per-output-channel accumulator words presented with the TPU's valid strobe and requantizes each word to 8-bit signed.
- Stores results in an internal ofmap buffer.
- Once capture completes, drains the buffer as a valid/ready stream (pixel-major, channel-minor) to the downstream writer or DMA.

Parameters:
- outputSize, 24, width of each incoming accumulator word (signed two's complement).
- numOutChannel, 3, output channels presented per valid cycle.
- numPixels, 256, buffer depth in pixels (per channel).
- outDataSize, 8, requantized output width (signed).
- localparam pixAddrSize = $clog2(numPixels).
- localparam chSize = $clog2(numOutChannel), minimum 1.

Ports:
- clk  input  1  clock
- nrst  input  1  reset, asynchronous, active-low
- in_data  input  [outputSize-1:0] x [numOutChannel] unpacked  deskewed accumulator outputs
- in_valid  input  1  in_data holds one valid pixel this cycle
- in_done  input  1  upstream processing finished (1-cycle pulse)
- ctrl_start  input  1  begin a capture/drain job
- cfg_num_pixels  input  16  pixels expected this job
- cfg_shift  input  5  right-shift amount for requantization
- out_data  output  outDataSize  requantized value
- out_pix  output  pixAddrSize  pixel index of out_data
- out_ch  output  chSize  channel index of out_data
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts
- flag_busy  output  1  state != IDLE
- flag_done  output  1  1-cycle pulse after last drain transfer
- flag_overflow  output  1  sticky: capture attempted beyond numPixels

Behaviour:
- Reset:
  - State IDLE.
  - All counters 0.
  - out_data, out_pix, out_ch, out_valid, flag_busy, flag_done and flag_overflow all 0.
  - Buffer contents are not cleared.
  - Reset mid-job aborts the job immediately; no flag_done is produced.
- FSM states: IDLE, CAPTURE, DRAIN.
- IDLE:
  - ctrl_start=1 latches cfg_num_pixels and cfg_shift, clears pix_cnt and flag_overflow, then goes to CAPTURE.
  - If latched num_pixels==0, go to DRAIN instead; DRAIN with zero pixels pulses flag_done on the next cycle and returns to IDLE.
  - ctrl_start is ignored in CAPTURE and DRAIN.
- CAPTURE:
  - Each cycle with in_valid=1 writes all numOutChannel requantized words to buffer[pix_cnt][ch] and increments pix_cnt.
  - If pix_cnt >= numPixels, data is dropped, flag_overflow is set, and pix_cnt still counts.
  - Transition to DRAIN when the write makes pix_cnt == num_pixels, or on in_done.
  - in_done together with in_valid in the same cycle: the pixel is captured first.
  - The captured count (clamped to numPixels) becomes the drain length.
  - in_valid in the cycle after the transition is ignored.
- Requantization:
  - Arithmetic right shift of signed in_data by the latched shift (floor rounding).
  - Saturate to [-2^(outDataSize-1), 2^(outDataSize-1)-1].
  - Shift >= outputSize yields 0 or -1 according to sign.
- DRAIN:
  - Read pointer walks pixel 0..len-1; for each pixel, ch 0..numOutChannel-1.
  - Buffer read is registered: out_valid first rises 1 cycle after entering DRAIN.
  - While out_valid=1 and out_ready=0, out_data, out_pix and out_ch hold stable.
  - On out_valid and out_ready, advance to the next element; with out_ready held high, one element transfers per cycle with no bubbles.
  - After the final element transfers: out_valid=0, flag_done=1 for exactly 1 cycle, then IDLE.
  - out_valid never asserts outside DRAIN.
- Latency: pixel captured at edge N is drainable no earlier than the DRAIN transition; there is no read-during-capture.

Test Plan:
- numOutChannel=3, cfg_num_pixels=4, shift=0, in_data pixel p ch c = 10*p+c, out_ready=1 -> 12 transfers in order (0,0)=0,(0,1)=1,(0,2)=2,(1,0)=10…(3,2)=32, on 12 consecutive cycles; flag_done pulses once; flag_busy falls with return to IDLE.
- Requant: shift=4, inputs 0x000100, 0x7FFFFF, 0xFFFFF0, 0x800000 -> outputs 16, 127, -1, -128.
- Backpressure: toggle out_ready 1,0,0,1 repeating -> every element is delivered exactly once, and outputs are unchanged while stalled.
- Early finish: cfg_num_pixels=10, 3 valid pixels then in_done coincident with the 3rd valid -> 9 transfers (3 pixels × 3 channels), then flag_done.
- Overflow: numPixels=4, cfg_num_pixels=6, 6 valids -> flag_overflow=1, only 12 transfers (4 pixels), then flag_done.
- Reset mid-DRAIN after 5 transfers -> all outputs 0 next cycle, no flag_done; a new ctrl_start with cfg_num_pixels=0 -> flag_done pulses 2 cycles after start with no out_valid.
